// File: rtl/palette_layer_arbiter_if.sv
// Pixel/palette bus of palette_layer_arbiter: layer requests in, shared palette
// lookup, and the registered colour toward the VGA mapper.
interface palette_layer_arbiter_if #(
  parameter int NUM_LAYERS = 4
);
  logic                      pix_valid;
  logic                      frame_start;
  logic [NUM_LAYERS-1:0]     layer_req;
  logic [3*NUM_LAYERS-1:0]   layer_index;
  logic                      blink;
  logic [2:0]                pal_index;
  logic [3:0]                pal_red;
  logic [3:0]                pal_green;
  logic [3:0]                pal_blue;
  logic [NUM_LAYERS-1:0]     grant;
  logic [3:0]                red;
  logic [3:0]                green;
  logic [3:0]                blue;
  logic                      rgb_valid;

  // Arbiter side
  modport master (
    input  pix_valid, frame_start, layer_req, layer_index, blink,
    input  pal_red, pal_green, pal_blue,
    output pal_index, grant, red, green, blue, rgb_valid
  );

  // Layer generators, palette and colour mapper side
  modport slave (
    output pix_valid, frame_start, layer_req, layer_index, blink,
    output pal_red, pal_green, pal_blue,
    input  pal_index, grant, red, green, blue, rgb_valid
  );
endinterface

// File: rtl/palette_layer_arbiter.sv
// Fixed-priority sprite layer arbiter sharing one palette lookup; two-stage pipeline.
// Optional hero blink sequencer compiled in with PALETTE_LAYER_BLINK_EN.
module palette_layer_arbiter #(
  parameter int NUM_LAYERS   = 4,
  parameter int BLINK_FRAMES = 8
) (
  input  logic Clk,
  input  logic Reset,
  palette_layer_arbiter_if.master bus
);
  logic [NUM_LAYERS-1:0] eligible;
  logic [NUM_LAYERS-1:0] grant_next;
  logic [2:0]            pal_index_next;
  logic                  mask_hero;

  logic [NUM_LAYERS-1:0] grant_reg;
  logic [2:0]            pal_index_reg;
  logic                  v1_reg;
  logic [3:0]            red_reg, green_reg, blue_reg;
  logic                  rgb_valid_reg;

  // Index 0 is the transparent key, so a zero index never competes.
  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_elig
      if (gi == 0) begin : g_hero
        assign eligible[gi] = bus.layer_req[gi] && (bus.layer_index[3*gi +: 3] != 3'd0) && !mask_hero;
      end else begin : g_other
        assign eligible[gi] = bus.layer_req[gi] && (bus.layer_index[3*gi +: 3] != 3'd0);
      end
    end
  endgenerate

  // Isolating the lowest set bit gives the highest-priority eligible layer.
  always_comb begin
    grant_next     = '0;
    pal_index_next = 3'd0;
    if (bus.pix_valid) begin
      grant_next = eligible & (~eligible + 1'b1);
    end
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (grant_next[i]) begin
        pal_index_next = bus.layer_index[3*i +: 3];
      end
    end
  end

`ifdef PALETTE_LAYER_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] frame_cnt_reg;
  logic       phase_reg;

  always_ff @(posedge Clk) begin
    if (Reset || !bus.blink) begin
      frame_cnt_reg <= 8'd0;
      phase_reg     <= 1'b0;
    end else if (bus.frame_start) begin
      if (frame_cnt_reg == BLINK_LAST) begin
        frame_cnt_reg <= 8'd0;
        phase_reg     <= ~phase_reg;
      end else begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  assign mask_hero = bus.blink && phase_reg;
`else
  logic unused_blink;
  assign unused_blink = bus.blink ^ bus.frame_start;
  assign mask_hero    = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant_reg     <= '0;
      pal_index_reg <= 3'd0;
      v1_reg        <= 1'b0;
      red_reg       <= 4'd0;
      green_reg     <= 4'd0;
      blue_reg      <= 4'd0;
      rgb_valid_reg <= 1'b0;
    end else begin
      grant_reg     <= grant_next;
      pal_index_reg <= pal_index_next;
      v1_reg        <= bus.pix_valid;
      rgb_valid_reg <= v1_reg;
      if (v1_reg) begin
        red_reg   <= bus.pal_red;
        green_reg <= bus.pal_green;
        blue_reg  <= bus.pal_blue;
      end else begin
        red_reg   <= 4'd0;
        green_reg <= 4'd0;
        blue_reg  <= 4'd0;
      end
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.pal_index = pal_index_reg;
  assign bus.red       = red_reg;
  assign bus.green     = green_reg;
  assign bus.blue      = blue_reg;
  assign bus.rgb_valid = rgb_valid_reg;
endmodule

// File: tb/tb_palette_layer_arbiter.sv
// Directed bench for palette_layer_arbiter: vector table plus blink and reset sequences.
module tb_palette_layer_arbiter;
  logic Clk = 1'b0;
  logic Reset;

  palette_layer_arbiter_if #(.NUM_LAYERS(4)) bus ();

  palette_layer_arbiter #(.NUM_LAYERS(4), .BLINK_FRAMES(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Shared palette contents used for all expected colours
  always_comb begin
    case (bus.pal_index)
      3'd0:    {bus.pal_red, bus.pal_green, bus.pal_blue} = 12'h04D;
      3'd1:    {bus.pal_red, bus.pal_green, bus.pal_blue} = 12'h222;
      3'd2:    {bus.pal_red, bus.pal_green, bus.pal_blue} = 12'h555;
      3'd3:    {bus.pal_red, bus.pal_green, bus.pal_blue} = 12'hECA;
      3'd4:    {bus.pal_red, bus.pal_green, bus.pal_blue} = 12'h0E1;
      3'd5:    {bus.pal_red, bus.pal_green, bus.pal_blue} = 12'hD30;
      3'd6:    {bus.pal_red, bus.pal_green, bus.pal_blue} = 12'h666;
      default: {bus.pal_red, bus.pal_green, bus.pal_blue} = 12'h987;
    endcase
  end

  typedef struct {
    logic        pv;
    logic [3:0]  req;
    logic [11:0] idx;
    logic [3:0]  grant;
    logic [2:0]  pal;
    logic [11:0] rgb;
    logic        rv;
  } vec_t;

  vec_t vecs [9];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [3:0]  exp_masked_grant;
  logic [11:0] exp_masked_rgb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [3:0] req, input logic [11:0] idx,
                       input logic bl, input logic fs);
    bus.pix_valid   = pv;
    bus.layer_req   = req;
    bus.layer_index = idx;
    bus.blink       = bl;
    bus.frame_start = fs;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [11:0] rgb_out();
    return {bus.red, bus.green, bus.blue};
  endfunction

  initial begin
    vecs[0] = '{1'b1, 4'b0011, 12'h00C, 4'b0001, 3'd4, 12'h0E1, 1'b1};
    vecs[1] = '{1'b1, 4'b0011, 12'h028, 4'b0010, 3'd5, 12'hD30, 1'b1};
    vecs[2] = '{1'b1, 4'b0000, 12'hFFF, 4'b0000, 3'd0, 12'h04D, 1'b1};
    vecs[3] = '{1'b0, 4'b1111, 12'hFFF, 4'b0000, 3'd0, 12'h000, 1'b0};
    vecs[4] = '{1'b1, 4'b1000, 12'hC00, 4'b1000, 3'd6, 12'h666, 1'b1};
    vecs[5] = '{1'b1, 4'b0100, 12'h1C3, 4'b0100, 3'd7, 12'h987, 1'b1};
    vecs[6] = '{1'b1, 4'b1111, 12'h000, 4'b0000, 3'd0, 12'h04D, 1'b1};
    vecs[7] = '{1'b1, 4'b1110, 12'h280, 4'b0100, 3'd2, 12'h555, 1'b1};
    vecs[8] = '{1'b1, 4'b0001, 12'h007, 4'b0001, 3'd7, 12'h987, 1'b1};

`ifdef PALETTE_LAYER_BLINK_EN
    exp_masked_grant = 4'b0100;
    exp_masked_rgb   = 12'h987;
`else
    exp_masked_grant = 4'b0001;
    exp_masked_rgb   = 12'hECA;
`endif

    Reset = 1'b1;
    drive(1'b1, 4'b1111, 12'hFFF, 1'b0, 1'b0);
    step();
    step();
    check("reset_grant", 32'(bus.grant), 32'h0);
    check("reset_pal_index", 32'(bus.pal_index), 32'h0);
    check("reset_rgb", 32'(rgb_out()), 32'h0);
    check("reset_rgb_valid", 32'(bus.rgb_valid), 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].pv, vecs[i].req, vecs[i].idx, 1'b0, 1'b0);
      step();
      check($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].grant));
      check($sformatf("vec%0d_pal_index", i), 32'(bus.pal_index), 32'(vecs[i].pal));
      step();
      check($sformatf("vec%0d_rgb", i), 32'(rgb_out()), 32'(vecs[i].rgb));
      check($sformatf("vec%0d_rgb_valid", i), 32'(bus.rgb_valid), 32'(vecs[i].rv));
      $display("vec %0d: grant=%b pal_index=%0d rgb=%03h rgb_valid=%0b",
               i, bus.grant, bus.pal_index, rgb_out(), bus.rgb_valid);
    end

    // Blink sequence: hero index 3, layer2 index 7, two frames per phase
    drive(1'b1, 4'b0101, 12'h1C3, 1'b1, 1'b0);
    step();
    check("blink_start_grant", 32'(bus.grant), 32'b0001);
    bus.frame_start = 1'b1;
    step();
    check("blink_pulse1_grant", 32'(bus.grant), 32'b0001);
    step();
    check("blink_pulse2_old_mask", 32'(bus.grant), 32'b0001);
    bus.frame_start = 1'b0;
    step();
    check("blink_phase1_grant", 32'(bus.grant), 32'(exp_masked_grant));
    step();
    check("blink_phase1_rgb", 32'(rgb_out()), 32'(exp_masked_rgb));
    $display("blink phase1: grant=%b rgb=%03h", bus.grant, rgb_out());
    bus.frame_start = 1'b1;
    step();
    step();
    bus.frame_start = 1'b0;
    step();
    check("blink_phase0_grant", 32'(bus.grant), 32'b0001);
    step();
    check("blink_phase0_rgb", 32'(rgb_out()), 32'hECA);
    $display("blink phase0: grant=%b rgb=%03h", bus.grant, rgb_out());

    // Enter masked phase, then drop blink: phase must clear
    bus.frame_start = 1'b1;
    step();
    step();
    bus.frame_start = 1'b0;
    step();
    check("blink_remask_grant", 32'(bus.grant), 32'(exp_masked_grant));
    bus.blink = 1'b0;
    step();
    check("blink_off_grant", 32'(bus.grant), 32'b0001);
    bus.blink = 1'b1;
    step();
    check("blink_cleared_grant", 32'(bus.grant), 32'b0001);
    $display("blink clear: grant=%b", bus.grant);

    // Reset pulse during a continuous valid stream
    drive(1'b1, 4'b0011, 12'h00C, 1'b0, 1'b0);
    step();
    step();
    check("stream_rgb", 32'(rgb_out()), 32'h0E1);
    Reset = 1'b1;
    step();
    check("midreset_grant", 32'(bus.grant), 32'h0);
    check("midreset_pal_index", 32'(bus.pal_index), 32'h0);
    check("midreset_rgb", 32'(rgb_out()), 32'h0);
    check("midreset_rgb_valid", 32'(bus.rgb_valid), 32'h0);
    Reset = 1'b0;
    step();
    check("post_reset1_grant", 32'(bus.grant), 32'b0001);
    check("post_reset1_rgb_valid", 32'(bus.rgb_valid), 32'h0);
    step();
    check("post_reset2_rgb", 32'(rgb_out()), 32'h0E1);
    check("post_reset2_rgb_valid", 32'(bus.rgb_valid), 32'h1);
    $display("reset resume: rgb=%03h rgb_valid=%0b", rgb_out(), bus.rgb_valid);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
